count_seq_checker: RTL and testbench
====================================

# count_seq_checker

Receive-side monitor for the free-running four-bit counter. It samples the counter's output bus and confirms that each sample equals the previous sample plus one, modulo 2^WIDTH. It locks onto a valid count sequence, flags and counts sequence breaks, and reports wrap-around events. It sits on the board next to the counter and drives LEDs and the error display, so the counter can be checked in hardware as well as in simulation.

## Interface
- WIDTH, 4: width of the monitored counter bus.
- LOCK_COUNT, 3: consecutive correct increments required to declare lock. Legal range is 1..15.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset. Low clears all state immediately, independent of clk.
- en  in  1  sample-valid; `a` is examined only on edges where en=1.
- a  in  WIDTH  counter value under test.
- clr_err  in  1  synchronous clear of err_count.
- locked  out  1  high while the sequence is being tracked correctly.
- err_pulse  out  1  one-cycle pulse: a sequence break was detected while locked.
- wrap_pulse  out  1  one-cycle pulse: a locked max→0 transition was detected.
- err_count  out  8  number of sequence breaks, saturating at 255.

## Operation
- The FSM has three states: IDLE, SYNC and LOCKED.
- Internal registers:
  - prev (WIDTH bits): last accepted sample.
  - run (4 bits): consecutive-match counter.
- match is defined as (a == prev + 1), computed in WIDTH-bit arithmetic, so max+1 == 0.
- State behaviour on en=1 edges:
  - IDLE: prev←a, run←0, go to SYNC. No compare is done on the first sample.
  - SYNC, match: run←run+1. If run+1 == LOCK_COUNT, go to LOCKED and set locked←1.
  - SYNC, mismatch: run←0, stay in SYNC. No error is counted; errors are counted only while locked.
  - LOCKED, match: stay in LOCKED. If prev == 2^WIDTH−1 and a == 0, pulse wrap_pulse.
  - LOCKED, mismatch: pulse err_pulse, increment err_count, set locked←0, run←0, go to SYNC.
- prev←a on every en=1 edge in every state.
- en=0 edges hold all state. err_pulse and wrap_pulse are 0 on those edges.
- err_count saturates at 255 and never wraps.
- clr_err sets err_count←0. If clr_err coincides with a new error, err_count←1.
- A repeated value (a == prev) counts as a mismatch. So does a decrement.

## Timing
- All outputs are registered. They change on the same rising edge that samples the triggering `a`, and are visible during the following cycle.
- Latency from the first sample to locked=1 is LOCK_COUNT+1 accepted samples. The first sample only primes prev.
- err_pulse and wrap_pulse are exactly one clk cycle wide and never asserted together.
- Reset values while rst=0:
  - state = IDLE
  - prev = 0
  - run = 0
  - locked = 0
  - err_pulse = 0
  - wrap_pulse = 0
  - err_count = 0
- Reset mid-operation (for example, while LOCKED) forces all of the above immediately, without waiting for a clock edge.
- After rst rises, the first en=1 edge is treated as an IDLE prime sample.
- No combinational path exists from an input to an output.

## Test plan
- **Lock:** rst=0 for 20 ns, then en=1 and a=0,1,2,3 on successive edges. locked=0 after the edges sampling 0..2, and locked=1 after the edge sampling 3. err_count=0 throughout.
- **Wrap:** while locked, drive a=14,15,0,1. wrap_pulse is high for exactly the cycle after 0 is sampled. locked stays 1 and err_count stays 0.
- **Break and relock:** while locked at a=3, drive 5. err_pulse=1 for one cycle, err_count=1, locked=0. Then drive 6,7,8: locked=1 again after 8, with no further errors.
- **Stall and repeat:** while locked, hold en=0 for 5 cycles with `a` changing. No state change occurs. Then en=1 with a==prev: err_pulse fires and err_count increments.
- **Saturation and clear:** generate 300 breaks. err_count stops at 255. Assert clr_err in the same cycle as a break: err_count=1. Assert clr_err alone: err_count=0.
- **Async reset:** while locked with err_count=7, pull rst low between clock edges. All outputs go to 0 before the next edge. Release rst and re-run the lock scenario: the same cycle counts are reproduced.

Source files
------------

// File: rtl/count_seq_checker.sv
// Receive-side monitor for a free-running counter: locks onto a +1 (mod 2^WIDTH)
// sequence, flags and counts breaks while locked, and reports locked wrap-arounds.
module count_seq_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}};
  localparam logic [3:0]       LOCK_RUN = 4'(LOCK_COUNT);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_prev;
  logic [3:0]       r_run;
  logic [3:0]       w_runNext;
  logic [3:0]       w_runInc;
  logic [WIDTH-1:0] w_prevInc;
  logic             w_match;
  logic             r_locked;
  logic             r_errPulse;
  logic             r_wrapPulse;
  logic [7:0]       r_errCount;
  logic             w_lockedNext;
  logic             w_errNext;
  logic             w_wrapNext;
  logic [7:0]       w_errCountNext;

  assign w_prevInc = r_prev + ONE;
  assign w_match   = (a == w_prevInc);
  assign w_runInc  = r_run + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_runNext   = r_run;
    if (en) begin
      case (r_state)
        IDLE: begin
          w_nextState = SYNC;
          w_runNext   = 4'd0;
        end
        SYNC: begin
          if (w_match) begin
            w_runNext = w_runInc;
            if (w_runInc == LOCK_RUN) begin
              w_nextState = LOCKED;
            end
          end else begin
            w_runNext = 4'd0;
          end
        end
        LOCKED: begin
          if (!w_match) begin
            w_nextState = SYNC;
            w_runNext   = 4'd0;
          end
        end
        default: begin
          w_nextState = IDLE;
          w_runNext   = 4'd0;
        end
      endcase
    end
  end

  // Next values of the registered outputs; a break is only an error while locked.
  always_comb begin
    w_errNext      = en && (r_state == LOCKED) && !w_match;
    w_wrapNext     = en && (r_state == LOCKED) && w_match && (r_prev == MAX);
    w_lockedNext   = (w_nextState == LOCKED);
    w_errCountNext = r_errCount;
    if (clr_err) begin
      w_errCountNext = w_errNext ? 8'd1 : 8'd0;
    end else if (w_errNext && (r_errCount != 8'hFF)) begin
      w_errCountNext = r_errCount + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev      <= '0;
      r_run       <= 4'd0;
      r_locked    <= 1'b0;
      r_errPulse  <= 1'b0;
      r_wrapPulse <= 1'b0;
      r_errCount  <= 8'd0;
    end else begin
      if (en) begin
        r_prev <= a;
      end
      r_run       <= w_runNext;
      r_locked    <= w_lockedNext;
      r_errPulse  <= w_errNext;
      r_wrapPulse <= w_wrapNext;
      r_errCount  <= w_errCountNext;
    end
  end

  assign locked     = r_locked;
  assign err_pulse  = r_errPulse;
  assign wrap_pulse = r_wrapPulse;
  assign err_count  = r_errCount;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed testbench for count_seq_checker: lock, wrap, break/relock, stall,
// saturation/clear and asynchronous reset scenarios with hand-computed expectations.
module tb_count_seq_checker;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] a;
  logic       clr_err;
  logic       locked;
  logic       err_pulse;
  logic       wrap_pulse;
  logic [7:0] err_count;

  int errors = 0;
  int checks = 0;
  logic [3:0] p;

  count_seq_checker #(.WIDTH(4), .LOCK_COUNT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .a         (a),
    .clr_err   (clr_err),
    .locked    (locked),
    .err_pulse (err_pulse),
    .wrap_pulse(wrap_pulse),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic drive(input logic e, input logic [3:0] v, input logic c);
    @(negedge clk);
    en      = e;
    a       = v;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #10;
    checks++;
    if ({locked, err_pulse, wrap_pulse, err_count} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got locked=%0b err=%0b wrap=%0b cnt=%0d, want all 0",
               locked, err_pulse, wrap_pulse, err_count);
    end
    #10;
    rst = 1'b1;
  endtask

  task automatic test_lock(input logic [7:0] expCount);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(i), 1'b0);
      checks++;
      if (locked !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL lock_locked a=%0d: got %0b want %0b", i, locked, (i == 3));
      end
      checks++;
      if (err_count !== expCount || err_pulse !== 1'b0) begin
        errors++;
        $display("[TB] FAIL lock_errs a=%0d: got cnt=%0d pulse=%0b want cnt=%0d pulse=0",
                 i, err_count, err_pulse, expCount);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 4; i < 14; i++) begin
      drive(1'b1, 4'(i), 1'b0);
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_prelock: got locked=%0b want 1", locked);
    end
    for (int i = 0; i < 4; i++) begin
      logic [3:0] v;
      v = 4'(14 + i);
      drive(1'b1, v, 1'b0);
      checks++;
      if (wrap_pulse !== (v == 4'd0)) begin
        errors++;
        $display("[TB] FAIL wrap_pulse a=%0d: got %0b want %0b", v, wrap_pulse, (v == 4'd0));
      end
      checks++;
      if (locked !== 1'b1 || err_count !== 8'd0 || err_pulse !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wrap_state a=%0d: got locked=%0b cnt=%0d err=%0b want 1/0/0",
                 v, locked, err_count, err_pulse);
      end
    end
  endtask

  task automatic test_break_relock();
    drive(1'b1, 4'd2, 1'b0);
    drive(1'b1, 4'd3, 1'b0);
    drive(1'b1, 4'd5, 1'b0);
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL break: got err=%0b cnt=%0d locked=%0b want 1/1/0",
               err_pulse, err_count, locked);
    end
    for (int i = 6; i < 9; i++) begin
      drive(1'b1, 4'(i), 1'b0);
      checks++;
      if (err_pulse !== 1'b0 || locked !== (i == 8) || err_count !== 8'd1) begin
        errors++;
        $display("[TB] FAIL relock a=%0d: got err=%0b locked=%0b cnt=%0d want 0/%0b/1",
                 i, err_pulse, locked, err_count, (i == 8));
      end
    end
  endtask

  task automatic test_stall_repeat();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'(3 * i + 1), 1'b0);
      checks++;
      if (locked !== 1'b1 || err_pulse !== 1'b0 || wrap_pulse !== 1'b0 || err_count !== 8'd1) begin
        errors++;
        $display("[TB] FAIL stall cycle %0d: got locked=%0b err=%0b wrap=%0b cnt=%0d want 1/0/0/1",
                 i, locked, err_pulse, wrap_pulse, err_count);
      end
    end
    drive(1'b1, 4'd8, 1'b0);
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 8'd2 || locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL repeat: got err=%0b cnt=%0d locked=%0b want 1/2/0",
               err_pulse, err_count, locked);
    end
    drive(1'b1, 4'd9, 1'b0);
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL repeat_pulse_width: got err=%0b want 0", err_pulse);
    end
    drive(1'b1, 4'd10, 1'b0);
    drive(1'b1, 4'd11, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL repeat_relock: got locked=%0b want 1", locked);
    end
    p = 4'd11;
  endtask

  // Each break: three matching increments to relock, then a repeated value.
  task automatic make_breaks(input int n, input logic c);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, p + 4'd1, 1'b0);
      drive(1'b1, p + 4'd2, 1'b0);
      drive(1'b1, p + 4'd3, 1'b0);
      p = p + 4'd3;
      drive(1'b1, p, c);
    end
  endtask

  task automatic test_saturation_clear();
    make_breaks(100, 1'b0);
    checks++;
    if (err_count !== 8'd102) begin
      errors++;
      $display("[TB] FAIL sat_mid: got cnt=%0d want 102", err_count);
    end
    make_breaks(200, 1'b0);
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("[TB] FAIL sat_final: got cnt=%0d want 255", err_count);
    end
    make_breaks(1, 1'b1);
    checks++;
    if (err_count !== 8'd1 || err_pulse !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr_with_break: got cnt=%0d err=%0b want 1/1", err_count, err_pulse);
    end
    drive(1'b0, 4'd0, 1'b1);
    checks++;
    if (err_count !== 8'd0 || err_pulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_alone: got cnt=%0d err=%0b want 0/0", err_count, err_pulse);
    end
    clr_err = 1'b0;
  endtask

  task automatic test_async_reset();
    make_breaks(7, 1'b0);
    drive(1'b1, p + 4'd1, 1'b0);
    drive(1'b1, p + 4'd2, 1'b0);
    drive(1'b1, p + 4'd3, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_count !== 8'd7) begin
      errors++;
      $display("[TB] FAIL areset_setup: got locked=%0b cnt=%0d want 1/7", locked, err_count);
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({locked, err_pulse, wrap_pulse, err_count} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL areset_immediate: got locked=%0b err=%0b wrap=%0b cnt=%0d want all 0",
               locked, err_pulse, wrap_pulse, err_count);
    end
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    test_lock(8'd0);
  endtask

  initial begin
    rst     = 1'b0;
    en      = 1'b0;
    a       = 4'd0;
    clr_err = 1'b0;
    p       = 4'd0;
    test_reset();
    test_lock(8'd0);
    test_wrap();
    test_break_relock();
    test_stall_repeat();
    test_saturation_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
